// File: rtl/port_ctl_if.sv
// CPU port bus between the processor core and the port controller.
// The core drives address, strobes and write data; the controller
// returns registered read data.
interface port_ctl_if;
    logic [15:0] pa;    // port address
    logic        pr;    // one-cycle read strobe
    logic        pw;    // one-cycle write strobe
    logic [7:0]  pout;  // CPU write data
    logic [7:0]  pin;   // registered read data

    modport master (
        output pa,
        output pr,
        output pw,
        output pout,
        input  pin
    );

    modport slave (
        input  pa,
        input  pr,
        input  pw,
        input  pout,
        output pin
    );
endinterface

// File: rtl/port_ctl.sv
// I/O port controller: keyboard scancode FIFO (ports 060h/064h, IRQ1)
// and the CRTC cursor registers (ports 3D4h/3D5h) behind one registered
// read path on the CPU port bus.
module port_ctl #(
    parameter int FIFO_AW = 4
) (
    input  logic         clock,
    input  logic         reset,
    port_ctl_if.slave    bus,
    input  logic         kb_done,
    input  logic [7:0]   kb_data,
    output logic         irq,
    output logic [10:0]  cursor,
    output logic [4:0]   cursor_start,
    output logic [4:0]   cursor_end,
    output logic         cursor_off
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [15:0] PORT_KB_DATA   = 16'h0060;
    localparam logic [15:0] PORT_KB_STATUS = 16'h0064;
    localparam logic [15:0] PORT_CRTC_IDX  = 16'h03D4;
    localparam logic [15:0] PORT_CRTC_DATA = 16'h03D5;

    localparam logic [7:0] CRTC_CUR_START = 8'h0A;
    localparam logic [7:0] CRTC_CUR_END   = 8'h0B;
    localparam logic [7:0] CRTC_CUR_HI    = 8'h0E;
    localparam logic [7:0] CRTC_CUR_LO    = 8'h0F;

    localparam logic [FIFO_AW-1:0] PTR_ONE    = 1;
    localparam logic [FIFO_AW:0]   CNT_ONE    = 1;
    localparam logic [FIFO_AW:0]   FULL_COUNT = {1'b1, {FIFO_AW{1'b0}}};

    // Scancode storage and FIFO bookkeeping
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   count_q,  count_d;
    logic [7:0]         last_key_q, last_key_d;
    logic               overflow_q, overflow_d;
    logic               irq_en_q,   irq_en_d;
    logic               irq_q,      irq_d;

    // CPU read data
    logic [7:0]         pin_q, pin_d;

    // CRTC state
    logic [7:0]         crtc_idx_q,     crtc_idx_d;
    logic [10:0]        cursor_q,       cursor_d;
    logic [4:0]         cur_start_q,    cur_start_d;
    logic [4:0]         cur_end_q,      cur_end_d;
    logic               cur_off_q,      cur_off_d;

    // Decoded bus cycles and FIFO conditions
    logic       nonempty;
    logic       full;
    logic       rd_kb_data;
    logic       rd_kb_status;
    logic       wr_kb_cmd;
    logic       flush;
    logic       push_req;
    logic       pop;
    logic       push;
    logic       overflow_set;
    logic [7:0] head;
    logic [7:0] status;
    logic [7:0] crtc_rdata;

    assign nonempty     = (count_q != '0);
    assign full         = (count_q == FULL_COUNT);
    assign head         = mem_q[rd_ptr_q];
    assign status       = {overflow_q, 5'b0, irq_en_q, nonempty};

    assign rd_kb_data   = bus.pr && (bus.pa == PORT_KB_DATA);
    assign rd_kb_status = bus.pr && (bus.pa == PORT_KB_STATUS);
    assign wr_kb_cmd    = bus.pw && (bus.pa == PORT_KB_STATUS);
    assign flush        = wr_kb_cmd && bus.pout[1];

    // A flush discards any scancode arriving in the same cycle. An empty
    // FIFO never pops, so a same-cycle push is not seen by that read.
    assign push_req     = kb_done && !flush && !reset;
    assign pop          = rd_kb_data && nonempty && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push         = push_req && (!full || pop);
    assign overflow_set = push_req && full && !pop;

    // CRTC data register read-back, unused bits as zero
    always_comb begin
        unique case (crtc_idx_q)
            CRTC_CUR_START: crtc_rdata = {2'b00, cur_off_q, cur_start_q};
            CRTC_CUR_END:   crtc_rdata = {3'b000, cur_end_q};
            CRTC_CUR_HI:    crtc_rdata = {5'b00000, cursor_q[10:8]};
            CRTC_CUR_LO:    crtc_rdata = cursor_q[7:0];
            default:        crtc_rdata = 8'hFF;
        endcase
    end

    // Next-state logic for read data, FIFO, status and CRTC registers
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block
        // leaves a signal unassigned, which would infer a latch.
        pin_d       = pin_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        last_key_d  = last_key_q;
        overflow_d  = overflow_q;
        irq_en_d    = irq_en_q;
        crtc_idx_d  = crtc_idx_q;
        cursor_d    = cursor_q;
        cur_start_d = cur_start_q;
        cur_end_d   = cur_end_q;
        cur_off_d   = cur_off_q;

        // Reads are decoded from pre-write state, so a read and a write in
        // the same cycle return the value held before the write.
        if (bus.pr) begin
            unique case (bus.pa)
                PORT_KB_DATA:   pin_d = nonempty ? head : last_key_q;
                PORT_KB_STATUS: pin_d = status;
                PORT_CRTC_IDX:  pin_d = crtc_idx_q;
                PORT_CRTC_DATA: pin_d = crtc_rdata;
                default:        pin_d = 8'hFF;
            endcase
        end

        if (pop) begin
            last_key_d = head;
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Status read clears overflow; a same-cycle overflow sets it again.
        if (rd_kb_status) begin
            overflow_d = 1'b0;
        end
        if (overflow_set) begin
            overflow_d = 1'b1;
        end

        if (wr_kb_cmd) begin
            irq_en_d = bus.pout[0];
        end
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end

        if (bus.pw && (bus.pa == PORT_CRTC_IDX)) begin
            crtc_idx_d = bus.pout;
        end
        if (bus.pw && (bus.pa == PORT_CRTC_DATA)) begin
            unique case (crtc_idx_q)
                CRTC_CUR_START: begin
                    cur_start_d = bus.pout[4:0];
                    cur_off_d   = bus.pout[5];
                end
                CRTC_CUR_END: cur_end_d      = bus.pout[4:0];
                CRTC_CUR_HI:  cursor_d[10:8] = bus.pout[2:0];
                CRTC_CUR_LO:  cursor_d[7:0]  = bus.pout;
                default: ;
            endcase
        end
    end

    // IRQ follows the FIFO state registered one cycle later
    assign irq_d = irq_en_q && nonempty;

    // Control and status registers with synchronous reset
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the same pre-edge values.
        if (reset) begin
            pin_q       <= 8'hFF;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            last_key_q  <= 8'h00;
            overflow_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            crtc_idx_q  <= 8'h00;
            cursor_q    <= 11'd0;
            cur_start_q <= 5'd6;
            cur_end_q   <= 5'd7;
            cur_off_q   <= 1'b0;
        end else begin
            pin_q       <= pin_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            last_key_q  <= last_key_d;
            overflow_q  <= overflow_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            crtc_idx_q  <= crtc_idx_d;
            cursor_q    <= cursor_d;
            cur_start_q <= cur_start_d;
            cur_end_q   <= cur_end_d;
            cur_off_q   <= cur_off_d;
        end
    end

    // Scancode storage write port
    always_ff @(posedge clock) begin
        // NOTE: the storage array is deliberately not reset; an entry is
        // only read after it has been written, as tracked by count_q.
        if (push) begin
            mem_q[wr_ptr_q] <= kb_data;
        end
    end

    assign bus.pin      = pin_q;
    assign irq          = irq_q;
    assign cursor       = cursor_q;
    assign cursor_start = cur_start_q;
    assign cursor_end   = cur_end_q;
    assign cursor_off   = cur_off_q;

endmodule

// File: doc/port_ctl.md
Name: port_ctl

Overview:
- I/O port controller between the CPU port bus (pa/pr/pw) and the on-board peripherals.
- Owns a scancode FIFO fed by the PS/2 receiver, with data port 060h, status/command port 064h and an IRQ1 request.
- Owns the CRTC index/data pair 3D4h/3D5h, which drives cursor position and shape to the text GPU.
- Replaces the inline port logic in the top level with one arbitrated, registered block.

Parameters:
- FIFO_AW, 4, log2 of the scancode FIFO depth (default depth 16).

Ports:
- clock  in  1  system clock (25 MHz).
- reset  in  1  synchronous, active-high reset.
- pa  in  16  port address from the CPU.
- pr  in  1  port read strobe, one cycle.
- pw  in  1  port write strobe, one cycle.
- pout  in  8  CPU write data.
- pin  out  8  registered read data to the CPU.
- kb_done  in  1  one-cycle strobe: new scancode valid.
- kb_data  in  8  scancode.
- irq  out  1  level IRQ1 request.
- cursor  out  11  cursor character offset.
- cursor_start  out  5  first cursor scanline.
- cursor_end  out  5  last cursor scanline.
- cursor_off  out  1  cursor disable.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - pin=FFh, irq=0, cursor=0, cursor_start=6, cursor_end=7, cursor_off=0.
  - FIFO empty, last_key=00h, overflow=0, irq_en=0, crtc_idx=00h.
- Read latency: pin is valid on the cycle after pr; it holds its value until the next pr.
- FIFO: 2^FIFO_AW entries of 8 bits, with rd/wr pointers and a count of FIFO_AW+1 bits. Pointers wrap modulo depth.
- Push on kb_done:
  - If count<depth, write kb_data at wr_ptr.
  - If full, drop the byte and set overflow=1.
- Read 060h:
  - If non-empty, pin<=head, last_key<=head, pop.
  - If empty, pin<=last_key and there is no pop.
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, push and pop in the same cycle is accepted with no overflow.
  - When empty, the pop does not occur, and a same-cycle push is not visible to that read.
- Read 064h:
  - pin<={overflow,5'b0,irq_en,nonempty}.
  - overflow is cleared after the read. A push-overflow in the same cycle re-sets it; set wins.
- Write 064h:
  - bit0 -> irq_en.
  - bit1=1 -> flush: pointers and count reset to 0, overflow cleared. A same-cycle kb_done is discarded.
- irq: registered copy of irq_en & nonempty. It updates one cycle after the FIFO state changes.
- Write 3D4h: crtc_idx<=pout. Read 3D4h returns crtc_idx.
- 3D5h registers, selected by crtc_idx:
  - 0Ah: bits4:0 cursor_start, bit5 cursor_off.
  - 0Bh: bits4:0 cursor_end.
  - 0Eh: bits2:0 cursor[10:8].
  - 0Fh: cursor[7:0].
- 3D5h reads return unused bits as 0. Any other index reads FFh and ignores writes.
- Unmapped ports: reads give pin<=FFh; writes are ignored.
- pr and pw in the same cycle: the write is applied, and the read returns the pre-write value.
- Reset mid-operation overrides everything, including a concurrent kb_done, pr or pw.

Test Plan:
1. Reset, then read 064h -> pin=00h and irq=0. Read 3D5h with idx 0Ah -> pin=06h.
2. Write 064h=01h, then kb_done with 1Ch then 32h:
   - irq=1 two cycles after the first push.
   - Read 060h twice -> 1Ch then 32h; irq drops after the second pop.
   - A third read -> 32h (last_key).
3. 17 pushes of 01h..11h with depth 16:
   - Read 064h -> 81h (irq_en=0); a second read -> 01h.
   - 16 reads of 060h -> 01h..10h.
4. Full FIFO, kb_done=55h in the same cycle as a read of 060h:
   - The read returns the old head and count stays 16.
   - The last entry popped is 55h and overflow stays 0.
5. Write 3D4h=0Eh, 3D5h=07h, 3D4h=0Fh, 3D5h=D0h -> cursor=7D0h. Write idx 0Ah=2Dh -> cursor_start=0Dh, cursor_off=1.
6. Write 064h=03h while 5 entries are queued, with kb_done in the same cycle -> the FIFO is empty, status reads 02h and irq=0 on the following cycle.
